// File: rtl/ser_tx.sv
// ser_tx -- parallel-in, serial-out transmitter for the des deserializer link.
//
// Accepts WIDTH-bit words over a valid/ready handshake into a one-word
// holding buffer, then shifts each word out LSB-first, one bit per clock.
// The three line outputs (dout, enable, load) wire straight to the
// receiver's din, enable and load.
//
// Ports:
//   clock      : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   tx_data    : word to transmit
//   tx_valid   : tx_data is valid
//   tx_ready   : holding buffer empty
//   dout       : serial data line (LSB first)
//   enable     : high for every bit cycle of a frame
//   load       : low for bit cycles 0..WIDTH-2, high on the last bit and in IDLE
//   busy       : frame in progress or a word waiting in the holding buffer
//   frame_cnt  : completed frames, wraps modulo 2^FCNT_W
//   dbg_state  : current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word transfers on every rising edge where tx_valid and
// tx_ready are both high. tx_ready depends only on registered state, so
// tx_valid/tx_data never reach an output combinationally; while tx_ready is
// low the inputs are ignored and the producer must hold its word.

module ser_tx #(
  parameter int WIDTH  = 32,
  parameter int FCNT_W = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              enable,
  output logic              load,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              dbg_state
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [WIDTH-1:0]  hold;
  logic              hold_full;
  logic [WIDTH-1:0]  shreg;
  logic [CW-1:0]     cnt;

  logic              accept;
  logic              reload;
  logic              advance;
  logic              frame_done;

  // Accept and reload are mutually exclusive: accept needs an empty buffer,
  // reload needs a full one.
  assign accept = tx_valid && !hold_full;

  always_comb begin
    state_d    = state;
    reload     = 1'b0;
    advance    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          reload  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          frame_done = 1'b1;
          // A waiting word starts on the very next cycle, so frames abut.
          if (hold_full) begin
            reload = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_d;

      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (reload) begin
        hold_full <= 1'b0;
      end

      if (reload) begin
        shreg <= hold;
        cnt   <= '0;
      end else if (advance) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end

      if (frame_done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // All outputs decode from registers only.
  assign tx_ready  = !hold_full;
  assign enable    = (state == SHIFT);
  assign dout      = (state == SHIFT) && shreg[0];
  // In IDLE load stays high so the receiver's bit counter sits at 0 for the
  // next frame start.
  assign load      = (state == IDLE) || (cnt == LAST);
  assign busy      = (state == SHIFT) || hold_full;
  assign dbg_state = (state == SHIFT);

endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx -- directed testbench for ser_tx.
//
// A line monitor acts as the receiver: it shifts dout in LSB-first while
// enable is high and, when load marks the last bit, compares the assembled
// word against the expected-word queue filled by the driver. A second
// instance with FCNT_W=2 shares the inputs to exercise frame counter wrap.

module tb_ser_tx;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          rst_n;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          dout;
  logic          enable;
  logic          load;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          dbg_state;

  logic          tx_ready2;
  logic          dout2;
  logic          enable2;
  logic          load2;
  logic          busy2;
  logic [1:0]    frame_cnt2;
  logic          dbg_state2;

  always #5 clock = ~clock;

  ser_tx #(.WIDTH(W), .FCNT_W(16)) u_dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dout      (dout),
    .enable    (enable),
    .load      (load),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  ser_tx #(.WIDTH(W), .FCNT_W(2)) u_dut2 (
    .clock     (clock),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready2),
    .dout      (dout2),
    .enable    (enable2),
    .load      (load2),
    .busy      (busy2),
    .frame_cnt (frame_cnt2),
    .dbg_state (dbg_state2)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           total  = 0;
  int           passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  // Line monitor / receiver model, sampled on the falling edge.
  logic [W-1:0] rx_word = '0;
  logic [W-1:0] rx_exp;
  int           bit_idx = 0;
  int           run = 0;
  int           last_run = 0;
  int           aborted = 0;
  int           frames_seen = 0;

  always @(negedge clock) begin
    if (enable === 1'b1) begin
      rx_word = {dout, rx_word[W-1:1]};
      bit_idx++;
      run++;
      if (load === 1'b1) begin
        check("frame_len", 32'(bit_idx), 32'd32);
        rx_exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~rx_word;
        check("frame_word", rx_word, rx_exp);
        frames_seen++;
        bit_idx = 0;
      end
    end else begin
      if (bit_idx != 0) begin
        aborted++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        bit_idx = 0;
      end
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Holds tx_valid until the word is taken (bounded wait).
  task automatic send(input logic [W-1:0] w);
    logic was_ready;
    int   n;
    n = 0;
    tx_valid = 1'b1;
    tx_data  = w;
    do begin
      was_ready = tx_ready;
      step(1);
      n++;
    end while (!was_ready && n < 400);
    tx_valid = 1'b0;
    check("accept_timeout", 32'(was_ready), 32'd1);
    exp_q.push_back(w);
    check("ready_low_after_accept", 32'(tx_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || enable !== 1'b0) && n < 400) begin
      step(1);
      n++;
    end
    check("idle_timeout", 32'(n < 400), 32'd1);
    step(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [W-1:0] wrap_words [5] = '{32'h0000_0003, 32'h8000_0001, 32'h5555_AAAA,
                                   32'h0F0F_F0F0, 32'h7FFF_FFFE};

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    step(2);

    // Reset state
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_load", 32'(load), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single word
    send(32'hA5A5_0F0F);
    step(1);
    check("single_bit0", 32'(dout), 32'd1);
    check("single_enable", 32'(enable), 32'd1);
    check("single_load_bit0", 32'(load), 32'd0);
    check("single_state", 32'(dbg_state), 32'd1);
    wait_idle();
    check("single_run", 32'(last_run), 32'd32);
    check("single_frame_cnt", 32'(frame_cnt), 32'd1);
    check("single_frames_seen", 32'(frames_seen), 32'd1);
    check("wrap_cnt_1", 32'(frame_cnt2), 32'd1);
    check("idle_load", 32'(load), 32'd1);
    check("idle_dout", 32'(dout), 32'd0);

    // Back-to-back plus backpressure on the waiting word
    send(32'hFFFF_FFFF);
    send(32'h0000_0001);
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = $urandom_range(32'hFFFF_FFFF, 0);
      step(1);
      check("bp_ready_low", 32'(tx_ready), 32'd0);
    end
    tx_valid = 1'b0;
    wait_idle();
    check("b2b_run", 32'(last_run), 32'd64);
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd3);
    check("b2b_frames_seen", 32'(frames_seen), 32'd3);
    check("wrap_cnt_3", 32'(frame_cnt2), 32'd3);

    // Reset mid-frame at bit 10 of 0x1234_5678 (bit 10 is 1)
    send(32'h1234_5678);
    step(11);
    check("mid_bit10", 32'(dout), 32'd1);
    pulse_reset();
    check("mid_rst_enable", 32'(enable), 32'd0);
    check("mid_rst_load", 32'(load), 32'd1);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step(1);
    check("mid_rst_aborted", 32'(aborted), 32'd1);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    send(32'hDEAD_BEEF);
    wait_idle();
    check("after_rst_run", 32'(last_run), 32'd32);
    check("after_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    // Loopback, three words back-to-back
    send(32'hCAFE_F00D);
    send(32'h8000_0000);
    send(32'h1234_5678);
    wait_idle();
    check("loop_run", 32'(last_run), 32'd96);
    check("loop_frame_cnt", 32'(frame_cnt), 32'd4);
    check("loop_frames_seen", 32'(frames_seen), 32'd7);
    check("wrap_cnt_0", 32'(frame_cnt2), 32'd0);

    // Counter wrap with FCNT_W = 2: 1,2,3,0,1
    pulse_reset();
    step(1);
    for (int i = 0; i < 5; i++) begin
      send(wrap_words[i]);
      wait_idle();
      check("wrap_seq", 32'(frame_cnt2), 32'(wrap_exp[i]));
      check("wrap_main_cnt", 32'(frame_cnt), 32'(i + 1));
    end
    check("aborted_total", 32'(aborted), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
